// File: rtl/rob_marker_collector_pkg.sv
// Shared types and constants for the ROB marker collector: marker codes,
// match constants, phase-pair indices, event record and collector states.
package rob_marker_pkg;

   typedef enum logic [3:0] {
      VCTM_START  = 4'h0,
      VCTM_END    = 4'h1,
      DELAY_START = 4'h2,
      DELAY_END   = 4'h3,
      TEXE_START  = 4'h4,
      TEXE_END    = 4'h5,
      LEAK_START  = 4'h6,
      LEAK_END    = 4'h7,
      INIT_START  = 4'h8,
      INIT_END    = 4'h9,
      BIM_START   = 4'hA,
      BIM_END     = 4'hB,
      TRAIN_START = 4'hC,
      TRAIN_END   = 4'hD,
      SIM_EXIT    = 4'hE
   } marker_code_e;

   localparam logic [7:0]  MARKER_HI = 8'h00;
   localparam logic [19:0] MARKER_LO = 20'h02013;

   localparam int unsigned PAIR_VCTM  = 0;
   localparam int unsigned PAIR_DELAY = 1;
   localparam int unsigned PAIR_TEXE  = 2;
   localparam int unsigned PAIR_LEAK  = 3;
   localparam int unsigned PAIR_INIT  = 4;
   localparam int unsigned PAIR_BIM   = 5;
   localparam int unsigned PAIR_TRAIN = 6;
   localparam int unsigned NUM_PAIRS  = 7;

   localparam int unsigned EVT_ID_WIDTH   = 8;
   localparam int unsigned EVT_LANE_WIDTH = 1;
   localparam int unsigned EVT_TS_WIDTH   = 32;

   typedef struct packed {
      marker_code_e                code;
      logic [EVT_ID_WIDTH-1:0]     id;
      logic [EVT_LANE_WIDTH-1:0]   lane;
      logic [EVT_TS_WIDTH-1:0]     ts;
   } marker_evt_t;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } collector_state_e;

   // slti x0,x0,imm with the reserved code 0xF excluded
   function automatic logic is_marker(input logic [31:0] inst);
      return (inst[31:24] == MARKER_HI) && (inst[19:0] == MARKER_LO) &&
             (inst[23:20] != 4'hF);
   endfunction

endpackage

// File: rtl/rob_marker_collector_if.sv
// Marker event stream from the collector to the event monitor.
interface rob_marker_collector_if #(
   parameter int unsigned ID_WIDTH = 8,
   parameter int unsigned LANE_W   = 1,
   parameter int unsigned TS_WIDTH = 32
);
   logic                evt_valid;
   logic                evt_ready;
   logic [3:0]          evt_code;
   logic [ID_WIDTH-1:0] evt_id;
   logic [LANE_W-1:0]   evt_lane;
   logic [TS_WIDTH-1:0] evt_time;

   modport master (output evt_valid, evt_code, evt_id, evt_lane, evt_time,
                   input  evt_ready);
   modport slave  (input  evt_valid, evt_code, evt_id, evt_lane, evt_time,
                   output evt_ready);
endinterface

// File: rtl/rob_marker_collector_fifo.sv
// Synchronous FIFO with NWR in-order write ports limited by free space
// at the start of the cycle, and one read port; occupancy has an extra bit.
module marker_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NWR   = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NWR-1:0]             wr_en,
   input  logic [NWR-1:0][WIDTH-1:0]  wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic [AW-1:0]    wr_idx [NWR];
   logic [NWR-1:0]   wr_ok;
   logic [AW:0]      n_wr, free;
   logic             rd_ok;

   // Enabled writes are packed into consecutive slots in port order
   always_comb begin
      free  = (AW+1)'(DEPTH) - count;
      n_wr  = '0;
      wr_ok = '0;
      for (int unsigned i = 0; i < NWR; i++) begin
         wr_idx[i] = wptr + n_wr[AW-1:0];
         if (wr_en[i] && (n_wr < free)) begin
            wr_ok[i] = 1'b1;
            n_wr     = n_wr + (AW+1)'(1);
         end
      end
   end

   assign empty   = (count == '0);
   assign rd_ok   = rd_en && !empty;
   assign rd_data = mem[rptr];

   always_ff @(posedge clock) begin
      for (int unsigned i = 0; i < NWR; i++) begin
         if (wr_ok[i]) mem[wr_idx[i]] <= wr_data[i];
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         wptr  <= wptr + n_wr[AW-1:0];
         if (rd_ok) rptr <= rptr + AW'(1);
         count <= count + n_wr - (AW+1)'(rd_ok);
      end
   end

endmodule

// File: rtl/rob_marker_collector.sv
// Detects and timestamps marker instructions on the ROB commit port, queues
// them for the event monitor and tracks phase windows and sim-exit state.
module rob_marker_collector
   import rob_marker_pkg::*;
#(
   parameter int unsigned COMMIT_WIDTH = 2,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned ID_WIDTH     = 8,
   parameter int unsigned TS_WIDTH     = 32
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [COMMIT_WIDTH-1:0]          commit_valid,
   input  logic [32*COMMIT_WIDTH-1:0]       commit_inst,
   input  logic [ID_WIDTH*COMMIT_WIDTH-1:0] commit_id,
   rob_marker_collector_if.master           evt,
   output logic [6:0]                       phase_active,
   output logic                             vctm_done,
   output logic                             sim_exit,
   output logic                             overflow,
   output logic [7:0]                       drop_count,
   output logic                             protocol_err
);
   localparam int unsigned LANE_W = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [3:0]          code;
      logic [ID_WIDTH-1:0] id;
      logic [LANE_W-1:0]   lane;
      logic [TS_WIDTH-1:0] ts;
   } evt_t;
   localparam int unsigned EVT_W = $bits(evt_t);

   collector_state_e state_q, state_d;
   logic [TS_WIDTH-1:0]                 ts_q;
   logic [3:0]                          lane_code [COMMIT_WIDTH];
   logic [COMMIT_WIDTH-1:0]             lane_mk, wr_en;
   logic [COMMIT_WIDTH-1:0][EVT_W-1:0]  wr_data;
   logic [EVT_W-1:0]                    rd_data;
   evt_t                                head;
   logic [CNT_W-1:0]                    count, slots;
   logic                                fifo_empty, rd_en, exit_enq, stop;
   logic [7:0]                          drops;
   logic [8:0]                          drop_sum;
   logic [6:0]                          phase_d;
   logic                                vctm_d, perr_d;

   always_comb begin
      for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
         lane_code[i] = commit_inst[32*i+20 +: 4];
         lane_mk[i]   = commit_valid[i] && is_marker(commit_inst[32*i +: 32]);
         wr_data[i]   = {lane_code[i], commit_id[ID_WIDTH*i +: ID_WIDTH],
                         LANE_W'(i), ts_q};
      end
   end

   // Lanes are walked in order; an accepted SIM_EXIT hides all later lanes
   always_comb begin
      wr_en    = '0;
      drops    = '0;
      exit_enq = 1'b0;
      phase_d  = phase_active;
      vctm_d   = vctm_done;
      perr_d   = protocol_err;
      stop     = (state_q != ST_RUN);
      slots    = CNT_W'(FIFO_DEPTH) - count;
      for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
         if (lane_mk[i] && !stop) begin
            if (slots != '0) begin
               wr_en[i] = 1'b1;
               slots    = slots - CNT_W'(1);
               if (lane_code[i] == SIM_EXIT) begin
                  stop     = 1'b1;
                  exit_enq = 1'b1;
               end
            end else begin
               drops = drops + 8'd1;
            end
            if ((lane_code[i] == VCTM_END) || (lane_code[i] == TEXE_START))
               vctm_d = 1'b1;
            if (lane_code[i] != SIM_EXIT) begin
               if (!lane_code[i][0])
                  phase_d[lane_code[i][3:1]] = 1'b1;
               else if (phase_d[lane_code[i][3:1]])
                  phase_d[lane_code[i][3:1]] = 1'b0;
               else
                  perr_d = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:   if (exit_enq) state_d = ST_DRAIN;
         ST_DRAIN: if (rd_en && (head.code == SIM_EXIT)) state_d = ST_DONE;
         default:  state_d = ST_DONE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) state_q <= ST_RUN;
      else        state_q <= state_d;
   end

   assign drop_sum = {1'b0, drop_count} + {1'b0, drops};

   always_ff @(posedge clock) begin
      if (!reset) begin
         ts_q         <= '0;
         phase_active <= '0;
         vctm_done    <= 1'b0;
         protocol_err <= 1'b0;
         overflow     <= 1'b0;
         drop_count   <= '0;
      end else begin
         ts_q         <= ts_q + TS_WIDTH'(1);
         phase_active <= phase_d;
         vctm_done    <= vctm_d;
         protocol_err <= perr_d;
         overflow     <= overflow | (drops != '0);
         drop_count   <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
   end

   marker_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EVT_W),
      .NWR   (COMMIT_WIDTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .count   (count),
      .empty   (fifo_empty)
   );

   assign head          = evt_t'(rd_data);
   assign evt.evt_valid = !fifo_empty && (state_q != ST_DONE);
   assign rd_en         = evt.evt_valid && evt.evt_ready;
   assign evt.evt_code  = evt.evt_valid ? head.code : '0;
   assign evt.evt_id    = evt.evt_valid ? head.id   : '0;
   assign evt.evt_lane  = evt.evt_valid ? head.lane : '0;
   assign evt.evt_time  = evt.evt_valid ? head.ts   : '0;
   assign sim_exit      = (state_q == ST_DONE);

endmodule

// File: tb/tb_rob_marker_collector.sv
// Directed bench for rob_marker_collector: per-cycle vector table plus
// overflow, same-cycle dequeue, exit and reset sequences.
module tb_rob_marker_collector;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  commit_valid;
   logic [63:0] commit_inst;
   logic [15:0] commit_id;
   logic [6:0]  phase_active;
   logic        vctm_done, sim_exit, overflow, protocol_err;
   logic [7:0]  drop_count;

   rob_marker_collector_if #(.ID_WIDTH(8), .LANE_W(1), .TS_WIDTH(32)) evt_if ();

   rob_marker_collector #(
      .COMMIT_WIDTH (2),
      .FIFO_DEPTH   (8),
      .ID_WIDTH     (8),
      .TS_WIDTH     (32)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .commit_valid (commit_valid),
      .commit_inst  (commit_inst),
      .commit_id    (commit_id),
      .evt          (evt_if),
      .phase_active (phase_active),
      .vctm_done    (vctm_done),
      .sim_exit     (sim_exit),
      .overflow     (overflow),
      .drop_count   (drop_count),
      .protocol_err (protocol_err)
   );

   always #5 clock = ~clock;

   // reference cycle counter: 0 in the first cycle after reset is released
   int unsigned cyc;
   always @(posedge clock) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   int nchecks = 0;
   int nerrs   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrs++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                        input logic [7:0] d0, input logic [7:0] d1);
      commit_valid = v;
      commit_inst  = {i1, i0};
      commit_id    = {d1, d0};
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   typedef struct {
      logic [1:0]  v;
      logic [31:0] i0, i1;
      logic [7:0]  d0, d1;
      logic        ev;
      logic [3:0]  code;
      logic [7:0]  id;
      logic        lane;
      int unsigned tb;
      logic [6:0]  ph;
      logic        vd;
      logic        pe;
   } vec_t;

   vec_t        tbl [16];
   int unsigned tcommit [5];

   initial begin
      tbl[0]  = '{2'b01, 32'h00402013, 32'h0,        8'h05, 8'h00, 1'b1, 4'h4, 8'h05, 1'b0, 1, 7'h04, 1'b1, 1'b0};
      tbl[1]  = '{2'b00, 32'h0,        32'h0,        8'h00, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 0, 7'h04, 1'b1, 1'b0};
      tbl[2]  = '{2'b11, 32'h00802013, 32'h00902013, 8'h01, 8'h02, 1'b1, 4'h8, 8'h01, 1'b0, 1, 7'h04, 1'b1, 1'b0};
      tbl[3]  = '{2'b00, 32'h0,        32'h0,        8'h00, 8'h00, 1'b1, 4'h9, 8'h02, 1'b1, 2, 7'h04, 1'b1, 1'b0};
      tbl[4]  = '{2'b00, 32'h0,        32'h0,        8'h00, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 0, 7'h04, 1'b1, 1'b0};
      tbl[5]  = '{2'b11, 32'h00f02013, 32'h01002013, 8'h03, 8'h04, 1'b0, 4'h0, 8'h00, 1'b0, 0, 7'h04, 1'b1, 1'b0};
      tbl[6]  = '{2'b01, 32'h00002093, 32'h00002013, 8'h05, 8'h06, 1'b0, 4'h0, 8'h00, 1'b0, 0, 7'h04, 1'b1, 1'b0};
      tbl[7]  = '{2'b00, 32'h0,        32'h0,        8'h00, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 0, 7'h04, 1'b1, 1'b0};
      tbl[8]  = '{2'b01, 32'h00302013, 32'h0,        8'h07, 8'h00, 1'b1, 4'h3, 8'h07, 1'b0, 1, 7'h04, 1'b1, 1'b1};
      tbl[9]  = '{2'b00, 32'h0,        32'h0,        8'h00, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 0, 7'h04, 1'b1, 1'b1};
      tbl[10] = '{2'b11, 32'h00502013, 32'h00402013, 8'h08, 8'h09, 1'b1, 4'h5, 8'h08, 1'b0, 1, 7'h04, 1'b1, 1'b1};
      tbl[11] = '{2'b00, 32'h0,        32'h0,        8'h00, 8'h00, 1'b1, 4'h4, 8'h09, 1'b1, 2, 7'h04, 1'b1, 1'b1};
      tbl[12] = '{2'b00, 32'h0,        32'h0,        8'h00, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 0, 7'h04, 1'b1, 1'b1};
      tbl[13] = '{2'b11, 32'h00402013, 32'h00c02013, 8'h0A, 8'h0B, 1'b1, 4'h4, 8'h0A, 1'b0, 1, 7'h44, 1'b1, 1'b1};
      tbl[14] = '{2'b00, 32'h0,        32'h0,        8'h00, 8'h00, 1'b1, 4'hC, 8'h0B, 1'b1, 2, 7'h44, 1'b1, 1'b1};
      tbl[15] = '{2'b00, 32'h0,        32'h0,        8'h00, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 0, 7'h44, 1'b1, 1'b1};

      drive(2'b00, 32'h0, 32'h0, 8'h0, 8'h0);
      evt_if.evt_ready = 1'b1;
      reset = 1'b0;
      repeat (3) step();
      chk("rst evt_valid", 64'(evt_if.evt_valid), 64'd0);
      chk("rst phase", 64'(phase_active), 64'd0);
      chk("rst vctm_done", 64'(vctm_done), 64'd0);
      chk("rst sim_exit", 64'(sim_exit), 64'd0);
      chk("rst overflow", 64'(overflow), 64'd0);
      chk("rst drop_count", 64'(drop_count), 64'd0);
      chk("rst protocol_err", 64'(protocol_err), 64'd0);
      reset = 1'b1;

      // first vector lands in the first cycle after release, so its stamp is 0
      for (int n = 0; n < 16; n++) begin
         drive(tbl[n].v, tbl[n].i0, tbl[n].i1, tbl[n].d0, tbl[n].d1);
         step();
         chk($sformatf("v%0d evt_valid", n), 64'(evt_if.evt_valid), 64'(tbl[n].ev));
         if (tbl[n].ev) begin
            chk($sformatf("v%0d evt_code", n), 64'(evt_if.evt_code), 64'(tbl[n].code));
            chk($sformatf("v%0d evt_id", n),   64'(evt_if.evt_id),   64'(tbl[n].id));
            chk($sformatf("v%0d evt_lane", n), 64'(evt_if.evt_lane), 64'(tbl[n].lane));
            chk($sformatf("v%0d evt_time", n), 64'(evt_if.evt_time), 64'(cyc - tbl[n].tb));
         end
         chk($sformatf("v%0d phase", n), 64'(phase_active), 64'(tbl[n].ph));
         chk($sformatf("v%0d vctm_done", n), 64'(vctm_done), 64'(tbl[n].vd));
         chk($sformatf("v%0d protocol_err", n), 64'(protocol_err), 64'(tbl[n].pe));
      end

      // Backpressure: 10 markers over 5 cycles into 8 slots
      evt_if.evt_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tcommit[c] = cyc;
         drive(2'b11, 32'h00802013, 32'h00a02013, 8'(8'h20 + 2*c), 8'(8'h21 + 2*c));
         step();
      end
      drive(2'b00, 32'h0, 32'h0, 8'h0, 8'h0);
      chk("ovf overflow", 64'(overflow), 64'd1);
      chk("ovf drop_count", 64'(drop_count), 64'd2);
      chk("ovf head id", 64'(evt_if.evt_id), 64'h20);
      step();
      chk("hold evt_valid", 64'(evt_if.evt_valid), 64'd1);
      chk("hold evt_id", 64'(evt_if.evt_id), 64'h20);
      chk("hold evt_code", 64'(evt_if.evt_code), 64'h8);
      chk("hold evt_time", 64'(evt_if.evt_time), 64'(tcommit[0]));
      evt_if.evt_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("drain%0d valid", k), 64'(evt_if.evt_valid), 64'd1);
         chk($sformatf("drain%0d id", k), 64'(evt_if.evt_id), 64'(8'h20 + k));
         chk($sformatf("drain%0d lane", k), 64'(evt_if.evt_lane), 64'(k % 2));
         chk($sformatf("drain%0d time", k), 64'(evt_if.evt_time), 64'(tcommit[k/2]));
         step();
      end
      chk("drain empty", 64'(evt_if.evt_valid), 64'd0);

      // Full FIFO: a same-cycle dequeue does not make room for a new marker
      evt_if.evt_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         drive(2'b11, 32'h00802013, 32'h00a02013, 8'(8'h30 + 2*c), 8'(8'h31 + 2*c));
         step();
      end
      evt_if.evt_ready = 1'b1;
      drive(2'b01, 32'h00802013, 32'h0, 8'h3F, 8'h00);
      step();
      drive(2'b00, 32'h0, 32'h0, 8'h0, 8'h0);
      chk("full drop_count", 64'(drop_count), 64'd3);
      chk("full head id", 64'(evt_if.evt_id), 64'h31);
      repeat (6) step();
      chk("full last valid", 64'(evt_if.evt_valid), 64'd1);
      chk("full last id", 64'(evt_if.evt_id), 64'h37);
      step();
      chk("full empty", 64'(evt_if.evt_valid), 64'd0);

      // Exit: lane 1 marker in the SIM_EXIT cycle is neither queued nor dropped
      drive(2'b11, 32'h00e02013, 32'h00002013, 8'h40, 8'h41);
      step();
      drive(2'b00, 32'h0, 32'h0, 8'h0, 8'h0);
      chk("exit evt_valid", 64'(evt_if.evt_valid), 64'd1);
      chk("exit evt_code", 64'(evt_if.evt_code), 64'hE);
      chk("exit evt_id", 64'(evt_if.evt_id), 64'h40);
      chk("exit sim_exit early", 64'(sim_exit), 64'd0);
      step();
      chk("done evt_valid", 64'(evt_if.evt_valid), 64'd0);
      chk("done sim_exit", 64'(sim_exit), 64'd1);
      chk("done drop_count", 64'(drop_count), 64'd3);
      chk("done phase", 64'(phase_active), 64'h74);
      drive(2'b01, 32'h00002013, 32'h0, 8'h42, 8'h00);
      step();
      drive(2'b00, 32'h0, 32'h0, 8'h0, 8'h0);
      step();
      chk("done ignore valid", 64'(evt_if.evt_valid), 64'd0);
      chk("done ignore phase", 64'(phase_active), 64'h74);
      chk("done sim_exit held", 64'(sim_exit), 64'd1);

      // Reset mid-operation with markers queued clears everything
      drive(2'b11, 32'h00002013, 32'h0, 8'h50, 8'h00);
      reset = 1'b0;
      step();
      drive(2'b00, 32'h0, 32'h0, 8'h0, 8'h0);
      chk("rst2 evt_valid", 64'(evt_if.evt_valid), 64'd0);
      chk("rst2 evt_code", 64'(evt_if.evt_code), 64'd0);
      chk("rst2 evt_id", 64'(evt_if.evt_id), 64'd0);
      chk("rst2 evt_lane", 64'(evt_if.evt_lane), 64'd0);
      chk("rst2 evt_time", 64'(evt_if.evt_time), 64'd0);
      chk("rst2 phase", 64'(phase_active), 64'd0);
      chk("rst2 vctm_done", 64'(vctm_done), 64'd0);
      chk("rst2 sim_exit", 64'(sim_exit), 64'd0);
      chk("rst2 overflow", 64'(overflow), 64'd0);
      chk("rst2 drop_count", 64'(drop_count), 64'd0);
      chk("rst2 protocol_err", 64'(protocol_err), 64'd0);
      reset = 1'b1;
      step();
      chk("rst2 stays empty", 64'(evt_if.evt_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, expected finish before 200000");
      $fatal(1);
   end

endmodule
